// File: rtl/bmp_stream_parser_pkg.sv
// Shared constants, state/error encodings and row-padding helper for the BMP stream parser.
package bmp_stream_parser_pkg;

  localparam logic [7:0] SIG_B = 8'h42;
  localparam logic [7:0] SIG_M = 8'h4D;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_SIG    = 3'd1,
    ERR_BPP    = 3'd2,
    ERR_COMP   = 3'd3,
    ERR_WIDTH  = 3'd4,
    ERR_HEIGHT = 3'd5,
    ERR_OFFSET = 3'd6
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_SKIP   = 3'd2,
    ST_PIXEL  = 3'd3,
    ST_PAD    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Rows are padded to a 4-byte boundary; only width mod 4 matters.
  function automatic logic [1:0] row_pad(input logic [1:0] width_lsb);
    logic [3:0] row_mod;
    row_mod = 4'(width_lsb) * 4'd3;
    return 2'(4'd4 - {2'b00, row_mod[1:0]});
  endfunction

endpackage

// File: rtl/bmp_pixel_packer.sv
// Assembles B,G,R bytes into one {R,G,B} pixel and holds it in a valid/ready output register.
module bmp_pixel_packer
  import bmp_stream_parser_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int COORD_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    byte_take,
  input  logic [BYTE_WIDTH-1:0]   byte_data,
  input  logic [COORD_W-1:0]      tag_x,
  input  logic [COORD_W-1:0]      tag_y,
  input  logic                    tag_last,
  input  logic                    out_ready,
  output logic                    can_accept,
  output logic                    is_r_byte,
  output logic                    out_valid,
  output logic [3*BYTE_WIDTH-1:0] out_pixel,
  output logic [COORD_W-1:0]      out_x,
  output logic [COORD_W-1:0]      out_y,
  output logic                    out_last
);

  logic [1:0]            phase_q;
  logic [BYTE_WIDTH-1:0] b_q;
  logic [BYTE_WIDTH-1:0] g_q;

  assign is_r_byte  = (phase_q == 2'd2);
  // A pixel held against back-pressure blocks all further input bytes.
  assign can_accept = !(out_valid && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 2'd0;
      b_q       <= '0;
      g_q       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      phase_q   <= 2'd0;
      b_q       <= '0;
      g_q       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (byte_take && is_r_byte) begin
        out_pixel <= {byte_data, g_q, b_q};
        out_x     <= tag_x;
        out_y     <= tag_y;
        out_last  <= tag_last;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (byte_take) begin
        case (phase_q)
          2'd0:    begin b_q <= byte_data; phase_q <= 2'd1; end
          2'd1:    begin g_q <= byte_data; phase_q <= 2'd2; end
          default: phase_q <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: rtl/bmp_stream_parser.sv
// Streaming parser for 24-bpp uncompressed BMP files: header validation, offset skip,
// row-padding removal and x/y-tagged pixel output.
//
// state  | meaning
// IDLE   | waiting for start, no bytes taken
// HEADER | capturing the 54 header bytes
// SKIP   | discarding bytes up to the pixel-data offset
// PIXEL  | packing B,G,R bytes into pixels
// PAD    | discarding row padding
// DONE   | image complete, trailing bytes discarded
// ERROR  | header rejected, err/err_code held
module bmp_stream_parser
  import bmp_stream_parser_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int HDR_SIZE   = 54,
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096,
  parameter int COORD_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [23:0]           out_pixel,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  out_last,
  output logic                  hdr_valid,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic [31:0]           data_offset,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code
);

  state_e       state_q, state_d;
  err_code_e    hdr_err;
  logic [5:0]   hdr_idx;
  logic [7:0]   sig_lo, sig_hi;
  logic [15:0]  bpp;
  logic [31:0]  compression;
  logic [31:0]  skip_cnt;
  logic [1:0]   pad_cnt;
  logic [COORD_W-1:0] x_q, y_q;
  logic         row_last_q;

  logic take, pk_take, r_take, pk_can_accept, pk_is_r;
  logic hdr_last_byte, at_row_end, last_row;
  logic [1:0] pad;

  assign take          = in_valid && in_ready;
  assign pk_take       = take && (state_q == ST_PIXEL);
  assign r_take        = pk_take && pk_is_r;
  assign hdr_last_byte = (hdr_idx == 6'(HDR_SIZE - 1));
  assign at_row_end    = (x_q == COORD_W'(img_width - 32'd1));
  assign last_row      = (y_q == COORD_W'(img_height - 32'd1));
  assign pad           = row_pad(img_width[1:0]);

  assign busy = (state_q == ST_HEADER) || (state_q == ST_SKIP) ||
                (state_q == ST_PIXEL)  || (state_q == ST_PAD);
  // The final pixel may still sit in the output register after the FSM reaches DONE.
  assign done = (state_q == ST_DONE) && !out_valid;

  // Checks are ordered; the first failing one sets the code.
  always_comb begin
    hdr_err = ERR_NONE;
    if (sig_lo != SIG_B || sig_hi != SIG_M)
      hdr_err = ERR_SIG;
    else if (bpp != 16'd24)
      hdr_err = ERR_BPP;
    else if (compression != 32'd0)
      hdr_err = ERR_COMP;
    else if (img_width == 32'd0 || img_width > 32'(MAX_WIDTH))
      hdr_err = ERR_WIDTH;
    else if ($signed(img_height) <= 32'sd0 || $signed(img_height) > $signed(32'(MAX_HEIGHT)))
      hdr_err = ERR_HEIGHT;
    else if (data_offset < 32'(HDR_SIZE))
      hdr_err = ERR_OFFSET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_HEADER, ST_SKIP, ST_DONE: in_ready = 1'b1;
      ST_PIXEL, ST_PAD:            in_ready = pk_can_accept;
      default:                     in_ready = 1'b0;
    endcase
    if (start) in_ready = 1'b0;

    if (start) begin
      state_d = ST_HEADER;
    end else begin
      case (state_q)
        ST_HEADER:
          if (take && hdr_last_byte) begin
            if (hdr_err != ERR_NONE)                 state_d = ST_ERROR;
            else if (data_offset == 32'(HDR_SIZE))   state_d = ST_PIXEL;
            else                                     state_d = ST_SKIP;
          end
        ST_SKIP:
          if (take && skip_cnt == 32'd1) state_d = ST_PIXEL;
        ST_PIXEL:
          if (r_take && at_row_end) begin
            if (pad != 2'd0)   state_d = ST_PAD;
            else if (last_row) state_d = ST_DONE;
          end
        ST_PAD:
          if (take && pad_cnt == 2'd1) state_d = row_last_q ? ST_DONE : ST_PIXEL;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx     <= '0;
      sig_lo      <= '0;
      sig_hi      <= '0;
      bpp         <= '0;
      compression <= '0;
      img_width   <= '0;
      img_height  <= '0;
      data_offset <= '0;
      hdr_valid   <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      skip_cnt    <= '0;
      pad_cnt     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_last_q  <= 1'b0;
    end else if (start) begin
      hdr_idx     <= '0;
      sig_lo      <= '0;
      sig_hi      <= '0;
      bpp         <= '0;
      compression <= '0;
      img_width   <= '0;
      img_height  <= '0;
      data_offset <= '0;
      hdr_valid   <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      skip_cnt    <= '0;
      pad_cnt     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HEADER:
          if (take) begin
            hdr_idx <= hdr_idx + 6'd1;
            case (hdr_idx)
              6'd0:  sig_lo             <= in_data;
              6'd1:  sig_hi             <= in_data;
              6'd10: data_offset[7:0]   <= in_data;
              6'd11: data_offset[15:8]  <= in_data;
              6'd12: data_offset[23:16] <= in_data;
              6'd13: data_offset[31:24] <= in_data;
              6'd18: img_width[7:0]     <= in_data;
              6'd19: img_width[15:8]    <= in_data;
              6'd20: img_width[23:16]   <= in_data;
              6'd21: img_width[31:24]   <= in_data;
              6'd22: img_height[7:0]    <= in_data;
              6'd23: img_height[15:8]   <= in_data;
              6'd24: img_height[23:16]  <= in_data;
              6'd25: img_height[31:24]  <= in_data;
              6'd28: bpp[7:0]           <= in_data;
              6'd29: bpp[15:8]          <= in_data;
              6'd30: compression[7:0]   <= in_data;
              6'd31: compression[15:8]  <= in_data;
              6'd32: compression[23:16] <= in_data;
              6'd33: compression[31:24] <= in_data;
              default: ;
            endcase
            if (hdr_last_byte) begin
              if (hdr_err != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= hdr_err;
              end else begin
                hdr_valid <= 1'b1;
                skip_cnt  <= data_offset - 32'(HDR_SIZE);
              end
            end
          end
        ST_SKIP:
          if (take) skip_cnt <= skip_cnt - 32'd1;
        ST_PIXEL:
          if (r_take) begin
            if (at_row_end) begin
              x_q        <= '0;
              y_q        <= y_q + 1'b1;
              row_last_q <= last_row;
              pad_cnt    <= pad;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        ST_PAD:
          if (take) pad_cnt <= pad_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  bmp_pixel_packer #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .COORD_W    (COORD_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (start),
    .byte_take  (pk_take),
    .byte_data  (in_data),
    .tag_x      (x_q),
    .tag_y      (y_q),
    .tag_last   (at_row_end && last_row),
    .out_ready  (out_ready),
    .can_accept (pk_can_accept),
    .is_r_byte  (pk_is_r),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed/randomized bench for bmp_stream_parser against a file-level reference model.
module tb_bmp_stream_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pixel;
  logic [15:0] out_x, out_y;
  logic        out_last;
  logic        hdr_valid;
  logic [31:0] img_width, img_height, data_offset;
  logic        busy, done, err;
  logic [2:0]  err_code;

  int checks = 0;
  int failures = 0;

  logic [7:0]  file_q[$];
  logic [23:0] exp_pix[$];
  int          exp_x[$], exp_y[$];
  bit          exp_last[$];
  logic [23:0] got_pix[$];
  int          got_x[$], got_y[$];
  bit          got_last[$];
  bit          saw_valid;

  bmp_stream_parser dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .hdr_valid(hdr_valid), .img_width(img_width), .img_height(img_height),
    .data_offset(data_offset), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (out_valid) saw_valid = 1'b1;
    if (out_valid && out_ready) begin
      got_pix.push_back(out_pixel);
      got_x.push_back(int'(out_x));
      got_y.push_back(int'(out_y));
      got_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_le(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) file_q.push_back(8'(v >> (8 * i)));
  endtask

  function automatic int hdr_model(input logic [7:0] s1, input int bpp, input int comp,
                                   input int w, input int h, input int off);
    if (s1 != 8'h4D) return 1;
    if (bpp != 24) return 2;
    if (comp != 0) return 3;
    if (w <= 0 || w > 4096) return 4;
    if (h <= 0 || h > 4096) return 5;
    if (off < 54) return 6;
    return 0;
  endfunction

  task automatic build_file(input int w, input int h, input int off, input logic [7:0] s1,
                            input int bpp, input int comp, input bit with_pixels);
    int pad;
    logic [23:0] p;
    file_q.delete(); exp_pix.delete(); exp_x.delete(); exp_y.delete(); exp_last.delete();
    pad = (4 - (3 * w) % 4) % 4;
    file_q.push_back(8'h42);
    file_q.push_back(s1);
    put_le(32'(off + h * (3 * w + pad)), 4);
    put_le(32'd0, 4);
    put_le(32'(off), 4);
    put_le(32'd40, 4);
    put_le(32'(w), 4);
    put_le(32'(h), 4);
    put_le(32'd1, 2);
    put_le(32'(bpp), 2);
    put_le(32'(comp), 4);
    for (int i = 0; i < 20; i++) file_q.push_back(8'h00);
    if (with_pixels) begin
      for (int i = 54; i < off; i++) file_q.push_back(8'($urandom()));
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          p = 24'($urandom());
          file_q.push_back(p[7:0]);
          file_q.push_back(p[15:8]);
          file_q.push_back(p[23:16]);
          exp_pix.push_back(p);
          exp_x.push_back(x);
          exp_y.push_back(y);
          exp_last.push_back(x == w - 1 && y == h - 1);
        end
        for (int k = 0; k < pad; k++) file_q.push_back(8'($urandom()));
      end
      for (int k = 0; k < 3; k++) file_q.push_back(8'($urandom()));
    end
  endtask

  task automatic clear_got();
    got_pix.delete(); got_x.delete(); got_y.delete(); got_last.delete();
    saw_valid = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h42;
    @(negedge clk);
    check({tag, " start_in_ready"}, 64'(in_ready), 64'd0);
    step();
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Feeds the first n bytes of file_q; optional 20-cycle out_ready stall after the first pixel.
  task automatic feed(input string tag, input int n, input bit stall_en);
    int idx = 0, cyc = 0, stall_left = 0;
    bit stalled = 1'b0, have_hold = 1'b0, acc;
    logic [23:0] hold = '0;
    while (idx < n && cyc < 3000) begin
      if (stall_en && !stalled && got_pix.size() == 1) begin
        stalled = 1'b1; stall_left = 20; out_ready = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = file_q[idx];
      @(negedge clk);
      acc = in_ready;
      if (stall_left > 0 && out_valid) begin
        if (have_hold) begin
          check({tag, " stall_pixel"}, 64'(out_pixel), 64'(hold));
          check({tag, " stall_in_ready"}, 64'(in_ready), 64'd0);
        end else begin
          hold = out_pixel; have_hold = 1'b1;
        end
      end
      step();
      if (acc) idx++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " bytes_fed"}, 64'(idx), 64'(n));
    if (stall_en) check({tag, " stall_seen"}, 64'(have_hold), 64'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, " pixel_count"}, 64'(got_pix.size()), 64'(exp_pix.size()));
    foreach (exp_pix[i]) begin
      if (i < got_pix.size()) begin
        check($sformatf("%s pix%0d", tag, i), 64'(got_pix[i]), 64'(exp_pix[i]));
        check($sformatf("%s x%0d", tag, i), 64'(got_x[i]), 64'(exp_x[i]));
        check($sformatf("%s y%0d", tag, i), 64'(got_y[i]), 64'(exp_y[i]));
        check($sformatf("%s last%0d", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
      end
    end
  endtask

  task automatic run_image(input string tag, input int w, input int h, input int off,
                           input bit stall_en, input bit do_start);
    int cyc = 0;
    out_ready = 1'b1;
    if (do_start) pulse_start(tag);
    build_file(w, h, off, 8'h4D, 24, 0, 1'b1);
    clear_got();
    feed(tag, file_q.size(), stall_en);
    while (cyc < 100) begin
      @(negedge clk);
      if (done) break;
      step();
      cyc++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " err"}, 64'(err), 64'd0);
    check({tag, " hdr_valid"}, 64'(hdr_valid), 64'd1);
    check({tag, " img_width"}, 64'(img_width), 64'(w));
    check({tag, " img_height"}, 64'(img_height), 64'(h));
    check({tag, " data_offset"}, 64'(data_offset), 64'(off));
    check_stream(tag);
    step();
  endtask

  task automatic run_bad(input string tag, input logic [7:0] s1, input int bpp,
                         input int w, input int h, input int off);
    pulse_start(tag);
    build_file(w, h, off, s1, bpp, 0, 1'b0);
    clear_got();
    feed(tag, 54, 1'b0);
    check({tag, " err"}, 64'(err), 64'd1);
    check({tag, " err_code"}, 64'(err_code), 64'(hdr_model(s1, bpp, 0, w, h, off)));
    check({tag, " hdr_valid"}, 64'(hdr_valid), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    in_valid = 1'b1; in_data = 8'h00;
    repeat (3) step();
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
    check({tag, " no_out_valid"}, 64'(saw_valid), 64'd0);
    check({tag, " err_held"}, 64'(err_code), 64'(hdr_model(s1, bpp, 0, w, h, off)));
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (3) step();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst pixel", {out_pixel, out_x, out_y, out_last}, 64'd0);
    check("rst flags", {hdr_valid, busy, done, err, err_code}, 64'd0);
    check("rst fields", {img_width, data_offset}, 64'd0);
    check("rst height", 64'(img_height), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("idle in_ready", 64'(in_ready), 64'd0);
    step();

    run_image("t1_2x2", 2, 2, 54, 1'b0, 1'b1);
    check("t1 last_count", 64'(got_last.sum() with (int'(item))), 64'd1);

    run_bad("t2_sig", 8'h4E, 24, 2, 2, 54);
    run_bad("t3_bpp", 8'h4D, 32, 2, 2, 54);
    run_bad("t3_height", 8'h4D, 24, 2, -2, 54);
    run_bad("t3_sig_bpp", 8'h4E, 32, 2, 2, 54);
    run_bad("t3_width", 8'h4D, 24, 5000, 2, 54);
    run_bad("t3_offset", 8'h4D, 24, 2, 2, 40);

    run_image("t4_4x1", 4, 1, 58, 1'b0, 1'b1);
    if (got_pix.size() > 0)
      check("t4 first_pixel", 64'(got_pix[0]), 64'({file_q[60], file_q[59], file_q[58]}));

    run_image("t5_3x3", 3, 3, 54, 1'b1, 1'b1);
    run_image("t5_5x2", 5, 2, 60, 1'b0, 1'b1);

    // Abort mid-PIXEL with a pixel pending, then parse a fresh file.
    out_ready = 1'b1;
    pulse_start("t6a");
    build_file(2, 2, 54, 8'h4D, 24, 0, 1'b1);
    out_ready = 1'b0;
    feed("t6a", 57, 1'b0);
    @(negedge clk);
    check("t6 pending_valid", 64'(out_valid), 64'd1);
    step();
    pulse_start("t6b");
    @(negedge clk);
    check("t6 dropped_valid", 64'(out_valid), 64'd0);
    check("t6 busy_header", 64'(busy), 64'd1);
    step();
    run_image("t6_new", 2, 2, 54, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the header.
    pulse_start("t7");
    build_file(2, 2, 54, 8'h4D, 24, 0, 1'b1);
    feed("t7", 24, 1'b0);
    check("t7 busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7 rst flags", {hdr_valid, busy, done, err, err_code, out_valid, out_last}, 64'd0);
    check("t7 rst fields", {img_width, data_offset}, 64'd0);
    check("t7 rst height", 64'(img_height), 64'd0);
    check("t7 rst pixel", {out_pixel, out_x, out_y}, 64'd0);
    check("t7 rst in_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
